drain_and_evacuate: RTL and testbench

Airlock controller that runs the reverse of the fill-and-pressurize sequence. On a begin request it drains the chamber, then pumps it down to vacuum and confirms a stable vacuum. It sits beside the fill-and-pressurize controller under the airlock top level and reads the same door and chamber sensor signals. It reports done or a coded fault.

---
 rtl/drain_and_evacuate.sv | 240 ++++++++++++++++++++++++
 tb/tb_drain_and_evacuate.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/drain_and_evacuate.sv
// Airlock drain-and-evacuate sequencer: drain, pump down, settle, done.
// Optional DANDE_RETRY_EN macro: first timeout re-runs the drain once.
//
// Ports:
//   Clock        rising-edge system clock
//   Reset        synchronous active-high reset
//   begin_DandE  level request to start the sequence
//   InnerClosed  inner door closed sensor
//   OuterClosed  outer door closed sensor
//   Pressurized  chamber pressurized sensor
//   Evacuated    chamber at vacuum sensor
//   DrainValve   drain valve open command
//   VacuumPump   vacuum pump run command
//   busy         high in DRAIN / EVACUATE / SETTLE
//   done_DandE   sequence completed
//   fault        sequence aborted
//   fault_code   00 none, 01 door, 10 timeout, 11 sensor conflict
module drain_and_evacuate #(
  parameter int DRAIN_CYCLES  = 8,
  parameter int EVAC_TIMEOUT  = 32,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       begin_DandE,
  input  logic       InnerClosed,
  input  logic       OuterClosed,
  input  logic       Pressurized,
  input  logic       Evacuated,
  output logic       DrainValve,
  output logic       VacuumPump,
  output logic       busy,
  output logic       done_DandE,
  output logic       fault,
  output logic [1:0] fault_code
);

  typedef enum logic [2:0] {
    IDLE,
    DRAIN,
    EVACUATE,
    SETTLE,
    DONE,
    FAULT
  } state_t;

  localparam logic [1:0] C_DOOR = 2'b01;
  localparam logic [1:0] C_TMO  = 2'b10;
  localparam logic [1:0] C_CONF = 2'b11;

  localparam logic [15:0] DRAIN_LAST  = 16'(DRAIN_CYCLES - 1);
  localparam logic [15:0] TMO_LAST    = 16'(EVAC_TIMEOUT - 1);
  localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYCLES - 1);

  state_t      state, state_n;
  logic [15:0] pcnt, pcnt_n;
  logic [15:0] tcnt, tcnt_n;
  logic [1:0]  code, code_n;

`ifdef DANDE_RETRY_EN
  logic retry, retry_n;
`endif

  logic doors_ok;
  logic conflict;
  logic tmo;

  assign doors_ok = InnerClosed & OuterClosed;
  assign conflict = Pressurized & Evacuated;
  // >= rather than == so a timeout cannot be skipped when
  // EVACUATE hands over to SETTLE on the terminal count.
  assign tmo      = (tcnt >= TMO_LAST);

  // State register
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state <= IDLE;
      pcnt  <= '0;
      tcnt  <= '0;
      code  <= '0;
`ifdef DANDE_RETRY_EN
      retry <= 1'b0;
`endif
    end else begin
      state <= state_n;
      pcnt  <= pcnt_n;
      tcnt  <= tcnt_n;
      code  <= code_n;
`ifdef DANDE_RETRY_EN
      retry <= retry_n;
`endif
    end
  end

  // Next-state logic
  always_comb begin
    state_n = state;
    pcnt_n  = pcnt;
    tcnt_n  = tcnt;
    code_n  = code;
`ifdef DANDE_RETRY_EN
    retry_n = retry;
`endif
    unique case (state)
      IDLE: begin
        if (begin_DandE) begin
          if (!doors_ok) begin
            state_n = FAULT;
            code_n  = C_DOOR;
          end else if (Evacuated && !Pressurized) begin
            state_n = DONE;
          end else begin
            state_n = DRAIN;
            pcnt_n  = '0;
          end
        end
      end
      DRAIN: begin
        pcnt_n = pcnt + 16'd1;
        if (!doors_ok) begin
          state_n = FAULT;
          code_n  = C_DOOR;
        end else if (conflict) begin
          state_n = FAULT;
          code_n  = C_CONF;
        end else if (pcnt == DRAIN_LAST) begin
          state_n = EVACUATE;
          tcnt_n  = '0;
        end
      end
      EVACUATE: begin
        tcnt_n = tcnt + 16'd1;
        if (!doors_ok) begin
          state_n = FAULT;
          code_n  = C_DOOR;
        end else if (conflict) begin
          state_n = FAULT;
          code_n  = C_CONF;
        end else if (Evacuated) begin
          state_n = SETTLE;
          pcnt_n  = '0;
        end else if (tmo) begin
`ifdef DANDE_RETRY_EN
          if (!retry) begin
            state_n = DRAIN;
            pcnt_n  = '0;
            retry_n = 1'b1;
          end else begin
            state_n = FAULT;
            code_n  = C_TMO;
          end
`else
          state_n = FAULT;
          code_n  = C_TMO;
`endif
        end
      end
      SETTLE: begin
        tcnt_n = tcnt + 16'd1;
        pcnt_n = pcnt + 16'd1;
        if (!doors_ok) begin
          state_n = FAULT;
          code_n  = C_DOOR;
        end else if (conflict) begin
          state_n = FAULT;
          code_n  = C_CONF;
        end else if (Evacuated && pcnt == SETTLE_LAST) begin
          // Completing the settle beats a coincident timeout.
          state_n = DONE;
        end else if (tmo) begin
`ifdef DANDE_RETRY_EN
          if (!retry) begin
            state_n = DRAIN;
            pcnt_n  = '0;
            retry_n = 1'b1;
          end else begin
            state_n = FAULT;
            code_n  = C_TMO;
          end
`else
          state_n = FAULT;
          code_n  = C_TMO;
`endif
        end else if (!Evacuated) begin
          // tcnt keeps running across the bounce.
          state_n = EVACUATE;
          pcnt_n  = '0;
        end
      end
      DONE: begin
        if (!begin_DandE) begin
          state_n = IDLE;
`ifdef DANDE_RETRY_EN
          retry_n = 1'b0;
`endif
        end
      end
      FAULT: begin
        state_n = FAULT;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // Moore output decode
  always_comb begin
    DrainValve = 1'b0;
    VacuumPump = 1'b0;
    busy       = 1'b0;
    done_DandE = 1'b0;
    fault      = 1'b0;
    fault_code = 2'b00;
    unique case (state)
      DRAIN: begin
        DrainValve = 1'b1;
        busy       = 1'b1;
      end
      EVACUATE: begin
        VacuumPump = 1'b1;
        busy       = 1'b1;
      end
      SETTLE: begin
        busy = 1'b1;
      end
      DONE: begin
        done_DandE = 1'b1;
      end
      FAULT: begin
        fault      = 1'b1;
        fault_code = code;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_drain_and_evacuate.sv
// Scoreboard bench for drain_and_evacuate.
// Stimulus queues expected outputs; a monitor checks after each edge.
module tb_drain_and_evacuate;

  logic       Clock = 1'b0;
  logic       Reset = 1'b1;
  logic       b  = 1'b0;
  logic       ic = 1'b1;
  logic       oc = 1'b1;
  logic       pr = 1'b0;
  logic       ev = 1'b0;
  logic       DrainValve;
  logic       VacuumPump;
  logic       busy;
  logic       done_DandE;
  logic       fault;
  logic [1:0] fault_code;

  drain_and_evacuate #(
    .DRAIN_CYCLES (4),
    .EVAC_TIMEOUT (16),
    .SETTLE_CYCLES(3)
  ) dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .begin_DandE(b),
    .InnerClosed(ic),
    .OuterClosed(oc),
    .Pressurized(pr),
    .Evacuated  (ev),
    .DrainValve (DrainValve),
    .VacuumPump (VacuumPump),
    .busy       (busy),
    .done_DandE (done_DandE),
    .fault      (fault),
    .fault_code (fault_code)
  );

  always #5 Clock = ~Clock;

  // {DrainValve, VacuumPump, busy, done, fault, fault_code}
  localparam logic [6:0] E_IDLE = 7'b0000000;
  localparam logic [6:0] E_DRN  = 7'b1010000;
  localparam logic [6:0] E_EVC  = 7'b0110000;
  localparam logic [6:0] E_STL  = 7'b0010000;
  localparam logic [6:0] E_DONE = 7'b0001000;
  localparam logic [6:0] E_F01  = 7'b0000101;
  localparam logic [6:0] E_F10  = 7'b0000110;
  localparam logic [6:0] E_F11  = 7'b0000111;

  typedef struct {
    logic [6:0] e;
    string      tag;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   passes = 0;

  exp_t       cur;
  logic [6:0] got;

  always begin
    @(posedge Clock);
    #1;
    if (q.size() > 0) begin
      cur = q.pop_front();
      got = {DrainValve, VacuumPump, busy,
             done_DandE, fault, fault_code};
      checks++;
      if (got === cur.e)
        passes++;
      else
        $display("FAIL %s: got %b expected %b",
                 cur.tag, got, cur.e);
    end
  end

  task automatic step(input int n, input logic [6:0] e,
                      input string tag);
    for (int i = 0; i < n; i++) begin
      Reset = 1'b0;
      q.push_back('{e, $sformatf("%s[%0d]", tag, i)});
      @(negedge Clock);
    end
  endtask

  task automatic rst(input string tag);
    Reset = 1'b1;
    q.push_back('{E_IDLE, tag});
    @(negedge Clock);
    Reset = 1'b0;
  endtask

  initial begin
    @(negedge Clock);

    // 1: happy path
    rst("rst1");
    b = 1; pr = 1; ev = 0;
    step(4, E_DRN, "hp_drain");
    pr = 0;
    step(5, E_EVC, "hp_evac");
    ev = 1;
    step(3, E_STL, "hp_settle");
    step(2, E_DONE, "hp_done_hold");
    b = 0;
    step(2, E_IDLE, "hp_idle");

    // 2: door abort in drain, then reset
    rst("rst2");
    b = 1; pr = 1; ev = 0;
    step(1, E_DRN, "door_drain");
    oc = 0;
    step(1, E_F01, "door_fault");
    oc = 1; b = 0;
    step(2, E_F01, "door_held");
    rst("door_rst");
    step(2, E_IDLE, "door_idle");

    // 3: timeout, begin dropped mid-sequence
    b = 1; pr = 0; ev = 0;
    step(4, E_DRN, "tmo_drain");
    b = 0;
    step(16, E_EVC, "tmo_evac");
`ifdef DANDE_RETRY_EN
    step(4, E_DRN, "tmo_redrain");
    step(16, E_EVC, "tmo_reevac");
`endif
    step(2, E_F10, "tmo_fault");

    // 4a: settle glitch then done
    rst("rst4a");
    b = 1; pr = 0; ev = 0;
    step(4, E_DRN, "gl_drain");
    step(2, E_EVC, "gl_evac");
    ev = 1;
    step(2, E_STL, "gl_settle1");
    ev = 0;
    step(1, E_EVC, "gl_back");
    ev = 1;
    step(3, E_STL, "gl_settle2");
    step(1, E_DONE, "gl_done");
    b = 0;
    step(1, E_IDLE, "gl_idle");

    // 4b: done coincides with timeout count
    rst("rst4b");
    b = 1; ev = 0;
    step(4, E_DRN, "dp_drain");
    step(10, E_EVC, "dp_evac");
    ev = 1;
    step(2, E_STL, "dp_settle1");
    ev = 0;
    step(1, E_EVC, "dp_back");
    ev = 1;
    step(3, E_STL, "dp_settle2");
    step(1, E_DONE, "dp_done");
    b = 0;
    step(1, E_IDLE, "dp_idle");

    // 4c: shifted glitch runs into timeout
    rst("rst4c");
    b = 1; ev = 0;
    step(4, E_DRN, "gt_drain");
    step(11, E_EVC, "gt_evac");
    ev = 1;
    step(2, E_STL, "gt_settle1");
    ev = 0;
    step(1, E_EVC, "gt_back");
    ev = 1;
    step(2, E_STL, "gt_settle2");
`ifdef DANDE_RETRY_EN
    step(4, E_DRN, "gt_redrain");
    step(1, E_EVC, "gt_reevac");
`else
    step(2, E_F10, "gt_fault");
`endif

    // 5: sensor conflict, and door beats conflict
    b = 1; pr = 0; ev = 0;
    rst("rst5");
    step(4, E_DRN, "cf_drain");
    step(1, E_EVC, "cf_evac");
    pr = 1; ev = 1;
    step(2, E_F11, "cf_fault");
    pr = 0; ev = 0;
    rst("rst5b");
    step(4, E_DRN, "cd_drain");
    step(1, E_EVC, "cd_evac");
    pr = 1; ev = 1; oc = 0;
    step(1, E_F01, "cd_fault");
    oc = 1; pr = 0; ev = 0; b = 0;

    // 6: already evacuated, door open at start, reset mid-run
    rst("rst6");
    b = 1; ev = 1;
    step(2, E_DONE, "ae_done");
    b = 0;
    step(1, E_IDLE, "ae_idle");
    ev = 0; ic = 0; b = 1;
    step(1, E_F01, "idle_door");
    ic = 1;
    rst("rst6b");
    step(2, E_DRN, "mid_drain");
    rst("mid_rst");
    b = 0;
    step(1, E_IDLE, "mid_idle");

    for (int i = 0; i < 10 && q.size() > 0; i++)
      @(negedge Clock);
    if (q.size() > 0) begin
      checks++;
      $display("FAIL drain_queue: got %0d pending expected 0",
               q.size());
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
